bank_access_ctrl: RTL and testbench

- Single-port sequencer in front of the four Hamming-coded memory banks.
- Accepts one read or write request at a time over a valid/ready handshake.
- Decodes the top two address bits into the bank select that drives the data demultiplexer, then generates a one-cycle bank enable/write strobe.
- For reads, waits a fixed bank latency, captures the selected bank's encoded word and returns it on a valid/ready response channel.

---
 rtl/bank_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_bank_access_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_access_ctrl.sv
// Single-port sequencer for four Hamming-coded memory banks.
// Accepts one read or write at a time and drives a one-cycle bank strobe.
// Reads wait READ_LATENCY cycles, capture the selected bank word and return it
// on a valid/ready response channel.
module bank_access_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 2,
    localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1,
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS,
    localparam int W            = ENCODED_WORD + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [W-1:0]          i_req_wdata,
    output logic [1:0]            o_bank_sel,
    output logic [3:0]            o_bank_en,
    output logic                  o_bank_we,
    output logic [ADDR_WIDTH-3:0] o_bank_addr,
    output logic [W-1:0]          o_bank_wdata,
    input  logic [W-1:0]          i_rdata0,
    input  logic [W-1:0]          i_rdata1,
    input  logic [W-1:0]          i_rdata2,
    input  logic [W-1:0]          i_rdata3,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [W-1:0]          o_rsp_rdata,
    output logic [1:0]            o_rsp_bank,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    state_t                state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic [W-1:0]          wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]          rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_bank_q, rsp_bank_d;
    logic [W-1:0]          rdata_sel;

    // Pick the read word of the bank chosen at request acceptance.
    always_comb begin
        rdata_sel = i_rdata0;
        case (sel_q)
            2'd0:    rdata_sel = i_rdata0;
            2'd1:    rdata_sel = i_rdata1;
            2'd2:    rdata_sel = i_rdata2;
            default: rdata_sel = i_rdata3;
        endcase
    end

    // State register and datapath registers; reset wins over every transition.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_bank_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_bank_q  <= rsp_bank_d;
        end
    end

    // Next-state logic; select/address/data change only on acceptance so the
    // downstream latching demultiplexers never see a glitch.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_bank_d  = rsp_bank_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    sel_d   = i_req_addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
                    addr_d  = i_req_addr[ADDR_WIDTH-3:0];
                    wdata_d = i_req_wdata;
                    state_d = i_req_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = rdata_sel;
                    rsp_bank_d  = sel_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One-hot bank strobe decoded from the access states only.
    always_comb begin
        o_bank_en = '0;
        if (state_q == S_WR || state_q == S_RD) begin
            o_bank_en = 4'b0001 << sel_q;
        end
    end

    assign o_req_ready  = (state_q == S_IDLE) && !i_rst;
    assign o_bank_we    = (state_q == S_WR);
    assign o_busy       = (state_q != S_IDLE);
    assign o_bank_sel   = sel_q;
    assign o_bank_addr  = addr_q;
    assign o_bank_wdata = wdata_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_rsp_bank   = rsp_bank_q;

endmodule

// File: tb/tb_bank_access_ctrl.sv
// Bench for bank_access_ctrl: three instances (READ_LATENCY 2, 1, 15) share
// one stimulus stream and are each compared every cycle against a
// transaction-timeline reference model.
module tb_bank_access_ctrl;

    localparam int W  = 13;
    localparam int AW = 6;
    localparam int NI = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic [W-1:0]  rd0, rd1, rd2, rd3;
    logic          rsp_ready;

    logic          req_ready  [NI];
    logic [1:0]    bank_sel   [NI];
    logic [3:0]    bank_en    [NI];
    logic          bank_we    [NI];
    logic [3:0]    bank_addr  [NI];
    logic [W-1:0]  bank_wdata [NI];
    logic          rsp_valid  [NI];
    logic [W-1:0]  rsp_rdata  [NI];
    logic [1:0]    rsp_bank   [NI];
    logic          busy       [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bank_access_ctrl #(
            .DATA_WIDTH  (8),
            .ADDR_WIDTH  (AW),
            .READ_LATENCY(lat_of(g))
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_req_valid (req_valid),
            .o_req_ready (req_ready[g]),
            .i_req_we    (req_we),
            .i_req_addr  (req_addr),
            .i_req_wdata (req_wdata),
            .o_bank_sel  (bank_sel[g]),
            .o_bank_en   (bank_en[g]),
            .o_bank_we   (bank_we[g]),
            .o_bank_addr (bank_addr[g]),
            .o_bank_wdata(bank_wdata[g]),
            .i_rdata0    (rd0),
            .i_rdata1    (rd1),
            .i_rdata2    (rd2),
            .i_rdata3    (rd3),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_rsp_bank  (rsp_bank[g]),
            .o_busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one outstanding transaction described by its
    // acceptance cycle; all timing is derived from the age of that request.
    bit           m_busy [NI];
    bit           m_we   [NI];
    int           m_acc  [NI];
    logic [1:0]   m_sel  [NI];
    logic [3:0]   m_addr [NI];
    logic [W-1:0] m_wdata[NI];
    bit           m_rv   [NI];
    logic [W-1:0] m_rd   [NI];
    logic [1:0]   m_rb   [NI];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] s);
        case (s)
            2'd0:    return rd0;
            2'd1:    return rd1;
            2'd2:    return rd2;
            default: return rd3;
        endcase
    endfunction

    task automatic model_reset(input int k);
        m_busy[k]  = 1'b0;
        m_we[k]    = 1'b0;
        m_acc[k]   = 0;
        m_sel[k]   = '0;
        m_addr[k]  = '0;
        m_wdata[k] = '0;
        m_rv[k]    = 1'b0;
        m_rd[k]    = '0;
        m_rb[k]    = '0;
    endtask

    // Inputs are already applied for this cycle: compare all instances with
    // the model, advance the model across the coming edge, move to next cycle.
    task automatic tick();
        #1;
        for (int k = 0; k < NI; k++) begin
            int    age;
            bit    strobe;
            string p;
            age    = cyc - m_acc[k];
            strobe = m_busy[k] && (age == 1);
            p      = $sformatf("L%0d.", lat_of(k));
            check({p, "req_ready"}, 64'(req_ready[k]), 64'(!m_busy[k] && !rst));
            check({p, "busy"}, 64'(busy[k]), 64'(m_busy[k]));
            check({p, "bank_en"}, 64'(bank_en[k]), strobe ? 64'(4'b0001 << m_sel[k]) : 64'd0);
            check({p, "bank_we"}, 64'(bank_we[k]), 64'(strobe && m_we[k]));
            check({p, "bank_sel"}, 64'(bank_sel[k]), 64'(m_sel[k]));
            check({p, "bank_addr"}, 64'(bank_addr[k]), 64'(m_addr[k]));
            check({p, "bank_wdata"}, 64'(bank_wdata[k]), 64'(m_wdata[k]));
            check({p, "rsp_valid"}, 64'(rsp_valid[k]), 64'(m_rv[k]));
            check({p, "rsp_rdata"}, 64'(rsp_rdata[k]), 64'(m_rd[k]));
            check({p, "rsp_bank"}, 64'(rsp_bank[k]), 64'(m_rb[k]));
        end
        for (int k = 0; k < NI; k++) begin
            int age;
            age = cyc - m_acc[k];
            if (rst) begin
                model_reset(k);
            end else if (!m_busy[k]) begin
                if (req_valid) begin
                    m_busy[k]  = 1'b1;
                    m_acc[k]   = cyc;
                    m_we[k]    = req_we;
                    m_sel[k]   = req_addr[AW-1:AW-2];
                    m_addr[k]  = req_addr[AW-3:0];
                    m_wdata[k] = req_wdata;
                end
            end else if (m_we[k]) begin
                if (age == 1) m_busy[k] = 1'b0;
            end else if (age == 1 + lat_of(k)) begin
                m_rv[k] = 1'b1;
                m_rb[k] = m_sel[k];
                m_rd[k] = pick(m_sel[k]);
            end else if (m_rv[k] && rsp_ready) begin
                m_rv[k]   = 1'b0;
                m_busy[k] = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && (m_busy[0] || m_busy[1] || m_busy[2]); i++) tick();
        check("drain_idle", 64'(busy[0] | busy[1] | busy[2]), 64'd0);
    endtask

    task automatic read_boundary_setup();
        rd0 = 13'h1FFF; rd1 = 13'h1FFF; rd2 = 13'h1FFF; rd3 = 13'h00F0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'b11_1111; req_wdata = '0;
    endtask

    initial begin
        int rise [NI];
        int acc;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rd0 = '0; rd1 = '0; rd2 = '0; rd3 = '0; rsp_ready = 1'b0;
        for (int k = 0; k < NI; k++) model_reset(k);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // 1: reset state, then a single write to bank 2
        tick();
        check("rst_en", 64'(bank_en[0]), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_ready_in_reset", 64'(req_ready[0]), 64'd0);
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'b10_0101; req_wdata = 13'h01A5;
        tick();
        req_valid = 1'b0;
        check("wr_sel", 64'(bank_sel[0]), 64'd2);
        check("wr_en", 64'(bank_en[0]), 64'h4);
        check("wr_we", 64'(bank_we[0]), 64'd1);
        check("wr_addr", 64'(bank_addr[0]), 64'h5);
        check("wr_wdata", 64'(bank_wdata[0]), 64'h1A5);
        check("wr_ready_busy", 64'(req_ready[0]), 64'd0);
        tick();
        check("wr_ready_back", 64'(req_ready[0]), 64'd1);

        // 2: read of bank 3, last in-bank address, latency 2
        drain();
        read_boundary_setup();
        tick();
        req_valid = 1'b0;
        check("rd_en", 64'(bank_en[0]), 64'h8);
        tick(); tick();
        check("rd_valid_c3", 64'(rsp_valid[0]), 64'd0);
        tick();
        check("rd_valid_c4", 64'(rsp_valid[0]), 64'd1);
        check("rd_rdata", 64'(rsp_rdata[0]), 64'h0F0);
        check("rd_bank", 64'(rsp_bank[0]), 64'd3);
        tick();
        check("rd_valid_c5", 64'(rsp_valid[0]), 64'd0);

        // 3: response back-pressured for 5 cycles with new requests offered
        drain();
        rd0 = 13'h0ABC; rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h02;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("bp_valid_first", 64'(rsp_valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'($urandom); req_addr = 6'($urandom);
            rd0 = 13'($urandom);
            tick();
            check("bp_valid_hold", 64'(rsp_valid[0]), 64'd1);
            check("bp_rdata_hold", 64'(rsp_rdata[0]), 64'h0ABC);
            check("bp_ready_low", 64'(req_ready[0]), 64'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        check("bp_idle_after", 64'(busy[0]), 64'd0);
        check("bp_ready_after", 64'(req_ready[0]), 64'd1);

        // 4: back-to-back writes to banks 0..3 with valid held high
        drain();
        req_valid = 1'b1; req_we = 1'b1;
        for (int unsigned b = 0; b < 4; b++) begin
            req_addr  = {2'(b), 4'(b)};
            req_wdata = 13'($urandom);
            tick();
            check("b2b_en", 64'(bank_en[0]), 64'(4'b0001 << b));
            check("b2b_ready_low", 64'(req_ready[0]), 64'd0);
            tick();
        end
        req_valid = 1'b0;

        // 5: reset asserted while a read waits on the bank
        drain();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'($urandom); rd0 = 13'h1234;
        rd1 = 13'h1234; rd2 = 13'h1234; rd3 = 13'h1234;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_en", 64'(bank_en[0]), 64'd0);
        check("mid_rst_we", 64'(bank_we[0]), 64'd0);
        check("mid_rst_sel", 64'(bank_sel[0]), 64'd0);
        check("mid_rst_addr", 64'(bank_addr[0]), 64'd0);
        check("mid_rst_wdata", 64'(bank_wdata[0]), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid[0]), 64'd0);
        check("mid_rst_rdata", 64'(rsp_rdata[0]), 64'd0);
        check("mid_rst_bank", 64'(rsp_bank[0]), 64'd0);
        check("mid_rst_busy", 64'(busy[0]), 64'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_ready", 64'(req_ready[0]), 64'd1);
        repeat (4) tick();

        // 6: response latency at every instantiated READ_LATENCY
        drain();
        read_boundary_setup();
        acc = cyc;
        for (int k = 0; k < NI; k++) rise[k] = -1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < NI; k++)
                if (rise[k] < 0 && rsp_valid[k]) rise[k] = cyc - acc;
            tick();
        end
        for (int k = 0; k < NI; k++)
            check($sformatf("L%0d.rsp_latency", lat_of(k)), 64'(rise[k]), 64'(lat_of(k) + 2));

        // Random traffic
        drain();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            req_valid = $urandom_range(0, 1) == 1;
            req_we    = 1'($urandom);
            req_addr  = 6'($urandom);
            req_wdata = 13'($urandom);
            rd0 = 13'($urandom); rd1 = 13'($urandom);
            rd2 = 13'($urandom); rd3 = 13'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
